// File: rtl/rsc_encoder.sv
// rsc_encoder -- LTE turbo constituent encoder (8-state RSC,
// feedback g0 = 1+D^2+D^3, parity g1 = 1+D+D^3) with BPSK mapping.
// Emits alternating systematic / parity soft words for every accepted
// information bit, optionally followed by trellis termination.
//
// Build option: define RSC_TAIL_EN to append the 3-step tail (6 words).
//   Without it, the block ends on the parity word of bit K and the
//   register is left unterminated.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   blklen        block length K (0 is ignored)
//   valid_blklen  start strobe, honoured only when idle
//   bit_in        information bit, taken on valid_in && ready
//   valid_in      bit_in qualifier
//   ready         encoder can take a bit this cycle
//   out           signed soft symbol (+AMP for 0, -AMP for 1)
//   valid_out     out qualifier, no backpressure
//   last_out      final word of the block
//   busy          block in progress (clears the cycle after last_out)
module rsc_encoder #(
  parameter logic signed [15:0] AMP = 16'sd64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        blklen,
  input  logic               valid_blklen,
  input  logic               bit_in,
  input  logic               valid_in,
  output logic               ready,
  output logic signed [15:0] out,
  output logic               valid_out,
  output logic               last_out,
  output logic               busy
);

`ifdef RSC_TAIL_EN
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t state, state_n;
  logic [2:0]  sr, sr_n;        // sr[0]=s1 (newest), sr[1]=s2, sr[2]=s3
  logic [15:0] cnt, cnt_n;      // bits accepted so far
  logic [15:0] k, k_n;          // latched block length
  logic        par, par_n;      // parity bit waiting to be emitted
  logic        ppend, ppend_n;  // sys word on out, parity goes next
`ifdef RSC_TAIL_EN
  logic [2:0]  tcnt, tcnt_n;    // tail word index 0..5
`endif
  logic               ready_n, valid_n, last_n, busy_n;
  logic signed [15:0] out_n;
  logic               fb, w, z;

  function automatic logic signed [15:0] bpsk(input logic b);
    return b ? -AMP : AMP;
  endfunction

  assign fb = sr[1] ^ sr[2];
  assign w  = bit_in ^ fb;
  assign z  = w ^ sr[0] ^ sr[2];

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    k_n     = k;
    par_n   = par;
    ppend_n = ppend;
`ifdef RSC_TAIL_EN
    tcnt_n  = tcnt;
`endif
    ready_n = ready;
    busy_n  = busy;
    out_n   = out;
    valid_n = 1'b0;
    last_n  = 1'b0;
    case (state)
      IDLE: begin
        ready_n = 1'b0;
        busy_n  = 1'b0;
        // busy still high means last_out is on the wire; wait one more cycle
        if (valid_blklen && blklen != 16'd0 && !busy) begin
          k_n     = blklen;
          cnt_n   = 16'd0;
          sr_n    = 3'b000;
          ppend_n = 1'b0;
`ifdef RSC_TAIL_EN
          tcnt_n  = 3'd0;
`endif
          ready_n = 1'b1;
          busy_n  = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (ppend) begin
          // parity word; this cycle doubles as the next acceptance slot
          out_n   = bpsk(par);
          valid_n = 1'b1;
          ppend_n = 1'b0;
          if (cnt == k) begin
            ready_n = 1'b0;
`ifdef RSC_TAIL_EN
            state_n = TAIL;
`else
            last_n  = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            ready_n = 1'b1;
          end
        end else if (valid_in && ready) begin
          out_n   = bpsk(bit_in);
          valid_n = 1'b1;
          par_n   = z;
          sr_n    = {sr[1], sr[0], w};
          cnt_n   = cnt + 16'd1;
          ppend_n = 1'b1;
          ready_n = 1'b0;
        end
      end
`ifdef RSC_TAIL_EN
      TAIL: begin
        valid_n = 1'b1;
        tcnt_n  = tcnt + 3'd1;
        if (!tcnt[0]) begin
          // input forced to fb, so the feedback node w is 0
          out_n = bpsk(fb);
          par_n = sr[0] ^ sr[2];
          sr_n  = {sr[1], sr[0], 1'b0};
        end else begin
          out_n = bpsk(par);
        end
        if (tcnt == 3'd5) begin
          last_n  = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= 3'b000;
      cnt       <= 16'd0;
      k         <= 16'd0;
      par       <= 1'b0;
      ppend     <= 1'b0;
`ifdef RSC_TAIL_EN
      tcnt      <= 3'd0;
`endif
      ready     <= 1'b0;
      busy      <= 1'b0;
      out       <= 16'sd0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      k         <= k_n;
      par       <= par_n;
      ppend     <= ppend_n;
`ifdef RSC_TAIL_EN
      tcnt      <= tcnt_n;
`endif
      ready     <= ready_n;
      busy      <= busy_n;
      out       <= out_n;
      valid_out <= valid_n;
      last_out  <= last_n;
    end
  end

endmodule
